dm_byte_store: RTL and testbench
================================

# dm_byte_store

Byte-enabled data memory for the pipelined MIPS core, sitting in the MEM stage directly downstream of the store-lane decoder.
- It consumes the 4-bit lane mask produced for SB/SH/SW, aligns the store data into the selected byte lanes and merges it into the addressed word on the clock edge.
- It returns the full addressed word combinationally for the load-extension stage.
- On every committed write it emits the course-standard write trace.

## Interface
Parameters:
- ADDR_W, 12, word-index width; depth = 2^ADDR_W words (4096 words = 16 KiB).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears every word.
- WE  in  1  store enable from MEM-stage control.
- storeSig  in  4  byte-lane mask, bit i = byte lane i (bits [8i+7:8i]).
- Addr  in  32  byte address from ALU.
- WD  in  32  raw rt value, unaligned (byte in WD[7:0], half in WD[15:0]).
- PC  in  32  PC of the instruction in MEM, used for the trace only.
- RD  out  32  word at Addr[ADDR_W+1:2], unshifted, unextended.

## Operation
- Word index = Addr[ADDR_W+1:2]; Addr[1:0] is ignored by the array, since lane selection comes only from storeSig; Addr[31:ADDR_W+2] is ignored, so addresses wrap.
- Lane alignment, decided from storeSig alone:
  - 4'b0001/0010/0100/1000: WD[7:0] replicated to all four lanes.
  - 4'b0011/1100: WD[15:0] replicated to both halves.
  - 4'b1111: WD unchanged.
- Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other mask, including 0000, is illegal: no array update and no trace line, even with WE=1.
- Merge: new_word = (old & ~M) | (aligned & M), where M expands each storeSig bit to 8 bits.
- Trace on each committed write: $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2],2'b00}, new_word). The full merged word is printed, not just the written lanes.
- RD is purely combinational from the current array content; the block performs no sign or zero extension.

## Timing
- Write latency: one edge. The array updates at the posedge where reset=0, WE=1 and storeSig is legal.
- Read latency: zero. RD follows Addr within the same cycle.
- Read-during-write to the same word: RD shows the old word for the whole write cycle and the new word from the following cycle.
- Back-to-back writes to the same word in consecutive cycles: the second merge uses the result of the first. Byte-by-byte SB sequences must accumulate correctly.
- Reset: at any posedge with reset=1, all 2^ADDR_W words become 32'h0.
  - Reset has priority over WE. No write and no trace occur in that cycle.
  - RD reads 0 from the following cycle.
  - Reset mid-sequence discards nothing pending, because there is no internal buffering.
- No outputs are registered. RD after reset = 0 for every address.

## Structure
- Shared package: lane-mask constants (LANE_B0..LANE_B3, LANE_H0, LANE_H1, LANE_W) and the opcode constants SB=6'b101000, SH=6'b101001, SW=6'b101011. These are shared with the lane decoder and the load extender.
- One combinational sub-module, dm_lane_align (storeSig, WD → aligned data, byte mask, legal flag). It is reused by the formal lane checker.
- Top module holds the array, the write/merge always block and the trace.

## Test plan
- Reset, then SW 0x12345678 to Addr 0x0000_0010 -> next cycle RD@0x10 = 32'h12345678; trace "@<PC>: *00000010 <= 12345678".
- Four SBs to 0x20..0x23 with WD = 0xAA, 0xBB, 0xCC, 0xDD and masks 0001, 0010, 0100, 1000 -> RD@0x20 = 32'hDDCCBBAA; each trace shows the growing merged word.
- SW 0xFFFFFFFF to 0x40, then SH WD=0x00001234 with mask 1100 -> RD@0x40 = 32'h1234FFFF.
- WE=1 with storeSig 4'b0101 and with 4'b0000 -> word unchanged, no trace.
- Write 0xCAFEBABE to 0x4; in the same cycle RD = old 0. Next cycle RD = 32'hCAFEBABE. Addr 0x0001_0004 reads the same word, confirming wrap.
- WE=1 and reset=1 on the same edge -> no trace; RD = 0 at every address checked: 0x0, 0x4, 0x3FFC.

Source files
------------

// File: rtl/dm_byte_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_byte_store_pkg
//  Description : Shared store-lane constants and MIPS store opcodes, used by
//                the lane decoder, the byte-store data memory and the load
//                extender.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_byte_store_pkg;

   // Byte-lane masks, bit i selects bits [8i+7:8i] of the word
   localparam logic [3:0] LANE_B0 = 4'b0001;
   localparam logic [3:0] LANE_B1 = 4'b0010;
   localparam logic [3:0] LANE_B2 = 4'b0100;
   localparam logic [3:0] LANE_B3 = 4'b1000;
   localparam logic [3:0] LANE_H0 = 4'b0011;
   localparam logic [3:0] LANE_H1 = 4'b1100;
   localparam logic [3:0] LANE_W  = 4'b1111;

   // Store opcodes
   localparam logic [5:0] SB = 6'b101000;
   localparam logic [5:0] SH = 6'b101001;
   localparam logic [5:0] SW = 6'b101011;

   // Lane mask a store opcode produces for a given byte offset; used by the
   // upstream lane decoder so both sides agree on the encoding.
   function automatic logic [3:0] store_lanes(input logic [5:0] op,
                                              input logic [1:0] off);
      logic [3:0] lanes;
      lanes = 4'b0000;
      case (op)
         SB:      lanes = LANE_B0 << off;
         SH:      lanes = off[1] ? LANE_H1 : LANE_H0;
         SW:      lanes = LANE_W;
         default: lanes = 4'b0000;
      endcase
      return lanes;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dm_lane_align
//  Description : Combinational store-lane aligner. Replicates the byte/half
//                of the raw store data into every lane, expands the lane mask
//                to a bit mask and flags whether the mask is a legal store.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_align
   import dm_byte_store_pkg::*;
(
   input  logic [3:0]  storeSig,
   input  logic [31:0] WD,
   output logic [31:0] aligned,
   output logic [31:0] bit_mask,
   output logic        legal
);

   // Alignment and legality are decided from the lane mask alone
   always_comb begin
      aligned = WD;
      legal   = 1'b0;
      case (storeSig)
         LANE_B0, LANE_B1, LANE_B2, LANE_B3: begin
            aligned = {4{WD[7:0]}};
            legal   = 1'b1;
         end
         LANE_H0, LANE_H1: begin
            aligned = {2{WD[15:0]}};
            legal   = 1'b1;
         end
         LANE_W: begin
            aligned = WD;
            legal   = 1'b1;
         end
         default: begin
            aligned = WD;
            legal   = 1'b0;
         end
      endcase
   end

   // Each lane bit widens to a full byte of the merge mask
   always_comb begin
      bit_mask = {{8{storeSig[3]}}, {8{storeSig[2]}},
                  {8{storeSig[1]}}, {8{storeSig[0]}}};
   end

endmodule
`default_nettype wire

// File: rtl/dm_byte_store.sv
`default_nettype none
// ============================================================================
//  Module      : dm_byte_store
//  Description : Byte-enabled MEM-stage data memory. Merges aligned store
//                data into the addressed word on the clock edge, returns the
//                raw addressed word combinationally and prints the write
//                trace for every committed store.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_byte_store
   import dm_byte_store_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WE,
   input  logic [3:0]  storeSig,
   input  logic [31:0] Addr,
   input  logic [31:0] WD,
   input  logic [31:0] PC,
   output logic [31:0] RD
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       aligned;
   logic [31:0]       bit_mask;
   logic              legal;
   logic [31:0]       old_word;
   logic [31:0]       new_word;
   logic              commit;
   logic              unused_bits;

   // Byte offset and upper address bits play no part in the array;
   // addresses simply wrap.
   assign word_idx    = Addr[ADDR_W+1:2];
   assign unused_bits = ^{Addr[31:ADDR_W+2], Addr[1:0], PC};

   dm_lane_align u_align (
      .storeSig (storeSig),
      .WD       (WD),
      .aligned  (aligned),
      .bit_mask (bit_mask),
      .legal    (legal)
   );

   // Read path and merged word, both straight from current array content
   always_comb begin
      old_word = mem[word_idx];
      new_word = (old_word & ~bit_mask) | (aligned & bit_mask);
      commit   = WE && legal && !reset;
      RD       = old_word;
   end

   // Array update: reset clears every word and overrides any store
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[ADDR_W'(i)] <= 32'h0;
         end
      end else if (commit) begin
         mem[word_idx] <= new_word;
      end
   end

`ifndef SYNTHESIS
   // Write trace, printed for each store that actually lands in the array
   always_ff @(posedge clk) begin
      if (commit) begin
         $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, new_word);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_byte_store.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_byte_store
//  Description : Directed self-checking bench for dm_byte_store.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_byte_store;

   logic        clk;
   logic        reset;
   logic        WE;
   logic [3:0]  storeSig;
   logic [31:0] Addr;
   logic [31:0] WD;
   logic [31:0] PC;
   logic [31:0] RD;

   int vectors;
   int miscompares;

   dm_byte_store #(.ADDR_W(12)) dut (
      .clk      (clk),
      .reset    (reset),
      .WE       (WE),
      .storeSig (storeSig),
      .Addr     (Addr),
      .WD       (WD),
      .PC       (PC),
      .RD       (RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One store: inputs applied at negedge, committed at the next posedge
   task automatic wr(input logic [3:0] sig, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] pc);
      @(negedge clk);
      WE       = 1'b1;
      storeSig = sig;
      Addr     = a;
      WD       = d;
      PC       = pc;
      @(posedge clk);
      #1;
      WE       = 1'b0;
      storeSig = 4'b0000;
   endtask

   // Combinational read of one address
   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      Addr = a;
      #1;
      d = RD;
   endtask

   task automatic test_reset;
      logic [31:0] addrs [3];
      logic [31:0] got;
      addrs = '{32'h0, 32'h10, 32'h3FFC};
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd(addrs[i], got);
         vectors++;
         if (got !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd addr=%h got=%h exp=%h", addrs[i], got, 32'h0);
         end
      end
   endtask

   task automatic test_sw;
      logic [31:0] got;
      wr(4'b1111, 32'h0000_0010, 32'h1234_5678, 32'h0040_0000);
      rd(32'h10, got);
      vectors++;
      if (got !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL sw got=%h exp=%h", got, 32'h1234_5678);
      end
   endtask

   task automatic test_sb_accumulate;
      logic [3:0]  sigs [4];
      logic [31:0] wds  [4];
      logic [31:0] exps [4];
      logic [31:0] got;
      sigs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      // Upper bits of WD are junk; only WD[7:0] may reach the lane
      wds  = '{32'h5555_55AA, 32'h0000_00BB, 32'hFFFF_FFCC, 32'h1234_56DD};
      exps = '{32'h0000_00AA, 32'h0000_BBAA, 32'h00CC_BBAA, 32'hDDCC_BBAA};
      for (int i = 0; i < 4; i++) begin
         wr(sigs[i], 32'h20 + 32'(i), wds[i], 32'h0040_0010 + 32'(4 * i));
         rd(32'h20, got);
         vectors++;
         if (got !== exps[i]) begin
            miscompares++;
            $display("FAIL sb_step%0d got=%h exp=%h", i, got, exps[i]);
         end
      end
   endtask

   task automatic test_sh;
      logic [31:0] got;
      wr(4'b1111, 32'h40, 32'hFFFF_FFFF, 32'h0040_0100);
      wr(4'b1100, 32'h42, 32'h0000_1234, 32'h0040_0104);
      rd(32'h40, got);
      vectors++;
      if (got !== 32'h1234_FFFF) begin
         miscompares++;
         $display("FAIL sh_hi got=%h exp=%h", got, 32'h1234_FFFF);
      end
      wr(4'b0011, 32'h40, 32'h9999_ABCD, 32'h0040_0108);
      rd(32'h40, got);
      vectors++;
      if (got !== 32'h1234_ABCD) begin
         miscompares++;
         $display("FAIL sh_lo got=%h exp=%h", got, 32'h1234_ABCD);
      end
   endtask

   task automatic test_illegal;
      logic [3:0]  sigs [3];
      logic [31:0] got;
      sigs = '{4'b0101, 4'b0000, 4'b0111};
      for (int i = 0; i < 3; i++) begin
         wr(sigs[i], 32'h40, 32'h1111_1111, 32'h0040_0200);
         rd(32'h40, got);
         vectors++;
         if (got !== 32'h1234_ABCD) begin
            miscompares++;
            $display("FAIL illegal_mask sig=%b got=%h exp=%h", sigs[i], got, 32'h1234_ABCD);
         end
      end
   endtask

   task automatic test_read_during_write;
      logic [31:0] got;
      @(negedge clk);
      WE       = 1'b1;
      storeSig = 4'b1111;
      Addr     = 32'h4;
      WD       = 32'hCAFE_BABE;
      PC       = 32'h0040_0300;
      #1;
      got = RD;
      vectors++;
      if (got !== 32'h0) begin
         miscompares++;
         $display("FAIL rdw_old got=%h exp=%h", got, 32'h0);
      end
      @(posedge clk);
      #1;
      WE       = 1'b0;
      storeSig = 4'b0000;
      got = RD;
      vectors++;
      if (got !== 32'hCAFE_BABE) begin
         miscompares++;
         $display("FAIL rdw_new got=%h exp=%h", got, 32'hCAFE_BABE);
      end
      rd(32'h0001_0004, got);
      vectors++;
      if (got !== 32'hCAFE_BABE) begin
         miscompares++;
         $display("FAIL wrap got=%h exp=%h", got, 32'hCAFE_BABE);
      end
      rd(32'hFFFF_C007, got);
      vectors++;
      if (got !== 32'hCAFE_BABE) begin
         miscompares++;
         $display("FAIL wrap_hi got=%h exp=%h", got, 32'hCAFE_BABE);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] got;
      // Three stores on consecutive edges to one word, no idle cycle
      @(negedge clk);
      WE = 1'b1; storeSig = 4'b0001; Addr = 32'h80; WD = 32'hFFFF_FF11; PC = 32'h0040_0400;
      @(negedge clk);
      storeSig = 4'b1000; Addr = 32'h83; WD = 32'h0000_0022; PC = 32'h0040_0404;
      @(negedge clk);
      storeSig = 4'b0010; Addr = 32'h81; WD = 32'hABCD_EF33; PC = 32'h0040_0408;
      @(negedge clk);
      WE = 1'b0; storeSig = 4'b0000;
      rd(32'h80, got);
      vectors++;
      if (got !== 32'h2200_3311) begin
         miscompares++;
         $display("FAIL back_to_back got=%h exp=%h", got, 32'h2200_3311);
      end
   endtask

   task automatic test_reset_priority;
      logic [31:0] addrs [5];
      logic [31:0] got;
      addrs = '{32'h0, 32'h4, 32'h3FFC, 32'h10, 32'h20};
      wr(4'b1111, 32'h3FFC, 32'h5A5A_5A5A, 32'h0040_0500);
      @(negedge clk);
      reset    = 1'b1;
      WE       = 1'b1;
      storeSig = 4'b1111;
      Addr     = 32'h4;
      WD       = 32'hDEAD_BEEF;
      PC       = 32'h0040_0504;
      @(negedge clk);
      reset    = 1'b0;
      WE       = 1'b0;
      storeSig = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         rd(addrs[i], got);
         vectors++;
         if (got !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_prio addr=%h got=%h exp=%h", addrs[i], got, 32'h0);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      WE          = 1'b0;
      storeSig    = 4'b0000;
      Addr        = 32'h0;
      WD          = 32'h0;
      PC          = 32'h0;

      test_reset;
      test_sw;
      test_sb_accumulate;
      test_sh;
      test_illegal;
      test_read_during_write;
      test_back_to_back;
      test_reset_priority;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
